// File: rtl/id_ex_if.sv
// Decode -> execute handshake bundle. Decode holds the master modport and the
// ID/EX buffer holds the slave modport.
interface id_ex_if #(
    parameter int unsigned N      = 16,
    parameter int unsigned REG_W  = 3,
    parameter int unsigned CTRL_W = 4
);
    logic              id_valid;
    logic [15:0]       id_instr;
    logic [CTRL_W-1:0] id_ctrl;
    logic [N-1:0]      id_src_val;
    logic [N-1:0]      id_dst_val;
    logic [REG_W-1:0]  id_src_reg;
    logic [REG_W-1:0]  id_dst_reg;
    logic              id_wb;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_in_port;
    logic              id_two_word;
    logic              flush;

    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [15:0]       ex_instr;
    logic [N-1:0]      ex_src_val;
    logic [N-1:0]      ex_dst_val;
    logic [REG_W-1:0]  ex_src_reg;
    logic [REG_W-1:0]  ex_dst_reg;
    logic              ex_wb;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_in_port;
    logic              stall;

    modport master (
        output id_valid, id_instr, id_ctrl, id_src_val, id_dst_val, id_src_reg, id_dst_reg,
               id_wb, id_mem_read, id_mem_write, id_in_port, id_two_word, flush,
        input  ex_valid, ex_ctrl, ex_instr, ex_src_val, ex_dst_val, ex_src_reg, ex_dst_reg,
               ex_wb, ex_mem_read, ex_mem_write, ex_in_port, stall
    );

    modport slave (
        input  id_valid, id_instr, id_ctrl, id_src_val, id_dst_val, id_src_reg, id_dst_reg,
               id_wb, id_mem_read, id_mem_write, id_in_port, id_two_word, flush,
        output ex_valid, ex_ctrl, ex_instr, ex_src_val, ex_dst_val, ex_src_reg, ex_dst_reg,
               ex_wb, ex_mem_read, ex_mem_write, ex_in_port, stall
    );
endinterface

// File: rtl/id_ex_buffer.sv
// ID/EX pipeline register: load-use bubble insertion, two-word instruction assembly, flush.
// Optional hazard-bubble counter enabled by defining PERF_BUBBLE_CNT_EN.
module id_ex_buffer #(
    parameter int unsigned N      = 16,
    parameter int unsigned REG_W  = 3,
    parameter int unsigned CTRL_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    id_ex_if.slave      bus,
    output logic [15:0] perf_bubbles_o
);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [15:0]       instr;
        logic [N-1:0]      src_val;
        logic [N-1:0]      dst_val;
        logic [REG_W-1:0]  src_reg;
        logic [REG_W-1:0]  dst_reg;
        logic              wb;
        logic              mem_read;
        logic              mem_write;
        logic              in_port;
    } ex_t;

    typedef enum logic [0:0] {StRun, StImmWait} state_e;

    state_e state_q, state_d;
    ex_t    ex_q, ex_d;
    ex_t    hold_q, hold_d;
    ex_t    id_word;
    logic   hazard;

    assign id_word = '{valid:     1'b1,
                       ctrl:      bus.id_ctrl,
                       instr:     bus.id_instr,
                       src_val:   bus.id_src_val,
                       dst_val:   bus.id_dst_val,
                       src_reg:   bus.id_src_reg,
                       dst_reg:   bus.id_dst_reg,
                       wb:        bus.id_wb,
                       mem_read:  bus.id_mem_read,
                       mem_write: bus.id_mem_write,
                       in_port:   bus.id_in_port};

    // Register compare is made even when the instruction does not use that operand.
    assign hazard = ex_q.valid & ex_q.mem_read & ex_q.wb & bus.id_valid & (state_q == StRun) &
                    ((ex_q.dst_reg == bus.id_src_reg) | (ex_q.dst_reg == bus.id_dst_reg));
    assign bus.stall = hazard & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (!bus.flush && !hazard && bus.id_valid && bus.id_two_word) state_d = StImmWait;
            end
            StImmWait: begin
                if (bus.flush || bus.id_valid) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        ex_d   = '0;
        hold_d = hold_q;
        unique case (state_q)
            StRun: begin
                if (bus.flush || hazard || !bus.id_valid) begin
                    ex_d = '0;
                end else if (bus.id_two_word) begin
                    hold_d = id_word;
                end else begin
                    ex_d = id_word;
                end
            end
            StImmWait: begin
                if (bus.flush) begin
                    hold_d = '0;
                end else if (bus.id_valid) begin
                    ex_d       = hold_q;
                    ex_d.instr = bus.id_instr;
                    ex_d.valid = 1'b1;
                end
            end
            default: ex_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q   <= '0;
            hold_q <= '0;
        end else begin
            ex_q   <= ex_d;
            hold_q <= hold_d;
        end
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_ctrl      = ex_q.ctrl;
    assign bus.ex_instr     = ex_q.instr;
    assign bus.ex_src_val   = ex_q.src_val;
    assign bus.ex_dst_val   = ex_q.dst_val;
    assign bus.ex_src_reg   = ex_q.src_reg;
    assign bus.ex_dst_reg   = ex_q.dst_reg;
    assign bus.ex_wb        = ex_q.wb;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_mem_write = ex_q.mem_write;
    assign bus.ex_in_port   = ex_q.in_port;

`ifdef PERF_BUBBLE_CNT_EN
    logic [15:0] bubbles_q, bubbles_d;

    // Only load-use bubbles count; saturates instead of wrapping.
    always_comb begin
        bubbles_d = bubbles_q;
        if (bus.stall && (bubbles_q != 16'hFFFF)) bubbles_d = bubbles_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubbles_q <= '0;
        end else begin
            bubbles_q <= bubbles_d;
        end
    end

    assign perf_bubbles_o = bubbles_q;
`else
    assign perf_bubbles_o = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_buffer.sv
// Directed-vector bench for id_ex_buffer: reset, issue, load-use stall, two-word
// assembly, flush interactions, async reset and the optional bubble counter.
module tb_id_ex_buffer;

    logic        clk;
    logic        rst_n;
    logic [15:0] perf_bubbles;
    int          n_checks;
    int          n_fails;
    logic [15:0] exp_perf;

    id_ex_if #(.N(16), .REG_W(3), .CTRL_W(4)) bus ();

    id_ex_buffer #(.N(16), .REG_W(3), .CTRL_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .perf_bubbles_o (perf_bubbles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] ctrl, input logic [15:0] instr,
                         input logic [15:0] sv, input logic [15:0] dv,
                         input logic [2:0] sr, input logic [2:0] dr,
                         input logic wb, input logic mr, input logic mw, input logic inp,
                         input logic two, input logic fl);
        bus.id_valid     = v;
        bus.id_ctrl      = ctrl;
        bus.id_instr     = instr;
        bus.id_src_val   = sv;
        bus.id_dst_val   = dv;
        bus.id_src_reg   = sr;
        bus.id_dst_reg   = dr;
        bus.id_wb        = wb;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
        bus.id_in_port   = inp;
        bus.id_two_word  = two;
        bus.flush        = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // LDD into rd issues, then an ADD using rs/rd is presented and must stall one cycle.
    task automatic load_use(input string tag, input logic [2:0] rd, input logic [2:0] a_src,
                            input logic [2:0] a_dst);
        drive(1'b1, 4'd9, 16'h0900, 16'h0010, 16'h0020, 3'd0, rd, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0);
        step();
        check({tag, "_ldd_issued"}, {31'd0, bus.ex_mem_read}, 32'd1);
        drive(1'b1, 4'd5, 16'h0500, 16'h0003, 16'h0004, a_src, a_dst, 1'b1, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0);
        #1;
        check({tag, "_stall_hi"}, {31'd0, bus.stall}, 32'd1);
        step();
        check({tag, "_bubble_valid"}, {31'd0, bus.ex_valid}, 32'd0);
        check({tag, "_bubble_ctrl"}, {28'd0, bus.ex_ctrl}, 32'd0);
        check({tag, "_stall_lo"}, {31'd0, bus.stall}, 32'd0);
        step();
        check({tag, "_add_ctrl"}, {28'd0, bus.ex_ctrl}, 32'd5);
        check({tag, "_add_valid"}, {31'd0, bus.ex_valid}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle();
        rst_n = 1'b0;
        #12;
        check("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_ctrl", {28'd0, bus.ex_ctrl}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_perf", {16'd0, perf_bubbles}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain ADD R1(3), R2(4)
        drive(1'b1, 4'd5, 16'h0512, 16'd3, 16'd4, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("add_ctrl", {28'd0, bus.ex_ctrl}, 32'd5);
        check("add_src_val", {16'd0, bus.ex_src_val}, 32'd3);
        check("add_dst_val", {16'd0, bus.ex_dst_val}, 32'd4);
        check("add_src_reg", {29'd0, bus.ex_src_reg}, 32'd1);
        check("add_dst_reg", {29'd0, bus.ex_dst_reg}, 32'd2);
        check("add_instr", {16'd0, bus.ex_instr}, 32'h0512);
        check("add_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("add_stall", {31'd0, bus.stall}, 32'd0);

        // Store with input-port flag passes control bits through
        drive(1'b1, 4'd10, 16'hA000, 16'hBEEF, 16'hCAFE, 3'd6, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1,
              1'b0, 1'b0);
        step();
        check("st_mem_write", {31'd0, bus.ex_mem_write}, 32'd1);
        check("st_in_port", {31'd0, bus.ex_in_port}, 32'd1);
        check("st_wb", {31'd0, bus.ex_wb}, 32'd0);
        check("st_dst_val", {16'd0, bus.ex_dst_val}, 32'hCAFE);

        idle();
        step();
        check("idle_bubble", {31'd0, bus.ex_valid}, 32'd0);

        load_use("lu1", 3'd3, 3'd3, 3'd4);
        load_use("lu2", 3'd6, 3'd1, 3'd6);
        load_use("lu3", 3'd2, 3'd2, 3'd2);

        // Flush overrides an active load-use hazard and is not counted
        drive(1'b1, 4'd9, 16'h0900, 16'h0, 16'h0, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'd5, 16'h0500, 16'd3, 16'd4, 3'd3, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("flush_hz_stall", {31'd0, bus.stall}, 32'd0);
        step();
        check("flush_hz_bubble", {31'd0, bus.ex_valid}, 32'd0);
        drive(1'b1, 4'd3, 16'h0333, 16'd7, 16'd8, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("flush_hz_run_ctrl", {28'd0, bus.ex_ctrl}, 32'd3);
        check("flush_hz_run_valid", {31'd0, bus.ex_valid}, 32'd1);

`ifdef PERF_BUBBLE_CNT_EN
        exp_perf = 16'd3;
`else
        exp_perf = 16'd0;
`endif
        check("perf_bubbles", {16'd0, perf_bubbles}, {16'd0, exp_perf});

        // LDM R5 with immediate 0x1234; second-word side fields are junk
        drive(1'b1, 4'd14, 16'hE050, 16'h0011, 16'h0022, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b0);
        step();
        check("ldm_e1_bubble", {31'd0, bus.ex_valid}, 32'd0);
        drive(1'b1, 4'd0, 16'h1234, 16'hFFFF, 16'hFFFF, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0);
        step();
        check("ldm_ctrl", {28'd0, bus.ex_ctrl}, 32'd14);
        check("ldm_instr", {16'd0, bus.ex_instr}, 32'h1234);
        check("ldm_dst_reg", {29'd0, bus.ex_dst_reg}, 32'd5);
        check("ldm_dst_val", {16'd0, bus.ex_dst_val}, 32'h0022);
        check("ldm_valid", {31'd0, bus.ex_valid}, 32'd1);

        // Idle cycle while waiting for the immediate keeps IMM_WAIT
        drive(1'b1, 4'd14, 16'hE060, 16'h0, 16'h0, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        idle();
        step();
        check("imm_idle_bubble", {31'd0, bus.ex_valid}, 32'd0);
        drive(1'b1, 4'd1, 16'hBEEF, 16'h0, 16'h0, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("imm_idle_ctrl", {28'd0, bus.ex_ctrl}, 32'd14);
        check("imm_idle_instr", {16'd0, bus.ex_instr}, 32'hBEEF);
        check("imm_idle_dst", {29'd0, bus.ex_dst_reg}, 32'd6);

        // Flush in IMM_WAIT discards the held LDM
        drive(1'b1, 4'd14, 16'hE070, 16'h0, 16'h0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 4'd0, 16'h5555, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("imm_flush_bubble", {31'd0, bus.ex_valid}, 32'd0);
        drive(1'b1, 4'd3, 16'h7777, 16'h0, 16'h0, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("imm_flush_run_ctrl", {28'd0, bus.ex_ctrl}, 32'd3);
        check("imm_flush_run_instr", {16'd0, bus.ex_instr}, 32'h7777);

        // Async reset with a valid instruction in EX clears without a clock edge
        rst_n = 1'b0;
        #2;
        check("async_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("async_rst_ctrl", {28'd0, bus.ex_ctrl}, 32'd0);
        check("async_rst_perf", {16'd0, perf_bubbles}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset while in IMM_WAIT returns the FSM to RUN
        drive(1'b1, 4'd14, 16'hE050, 16'h0, 16'h0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 4'd3, 16'h7777, 16'h0, 16'h0, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("imm_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("imm_rst_run_ctrl", {28'd0, bus.ex_ctrl}, 32'd3);
        check("imm_rst_run_instr", {16'd0, bus.ex_instr}, 32'h7777);
        check("imm_rst_run_valid", {31'd0, bus.ex_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
